// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and the opcode set used by
// the dispatcher, reservation station and execution unit.
package alu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ROB_W = 4;
  localparam int unsigned OP_W  = 6;

  typedef enum logic [OP_W-1:0] {
    OP_LUI   = 6'd0,
    OP_AUIPC = 6'd1,
    OP_JAL   = 6'd2,
    OP_JALR  = 6'd3,
    OP_BEQ   = 6'd4,
    OP_BNE   = 6'd5,
    OP_BLT   = 6'd6,
    OP_BGE   = 6'd7,
    OP_BLTU  = 6'd8,
    OP_BGEU  = 6'd9,
    OP_ADDI  = 6'd10,
    OP_SLTI  = 6'd11,
    OP_SLTIU = 6'd12,
    OP_XORI  = 6'd13,
    OP_ORI   = 6'd14,
    OP_ANDI  = 6'd15,
    OP_SLLI  = 6'd16,
    OP_SRLI  = 6'd17,
    OP_SRAI  = 6'd18,
    OP_ADD   = 6'd19,
    OP_SUB   = 6'd20,
    OP_SLL   = 6'd21,
    OP_SLT   = 6'd22,
    OP_SLTU  = 6'd23,
    OP_XOR   = 6'd24,
    OP_SRL   = 6'd25,
    OP_SRA   = 6'd26,
    OP_OR    = 6'd27,
    OP_AND   = 6'd28
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I integer/branch/jump evaluation: result, control-flow
// flag, resolved direction and next PC.
module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [XLEN-1:0] val1,
  input  logic [XLEN-1:0] val2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] res,
  output logic            is_br,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_sum;
  logic [4:0]      shamt_i;
  logic [4:0]      shamt_r;
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic            cond_br;

  assign pc_plus4    = pc + XLEN'(4);
  assign pc_plus_imm = pc + imm;
  assign jalr_sum    = val1 + imm;
  assign shamt_i     = imm[4:0];
  assign shamt_r     = val2[4:0];
  assign eq          = (val1 == val2);
  assign lt_s        = ($signed(val1) < $signed(val2));
  assign lt_u        = (val1 < val2);

  always_comb begin
    res     = '0;
    is_br   = 1'b0;
    taken   = 1'b0;
    target  = pc_plus4;
    cond_br = 1'b0;
    case (alu_op_e'(opcode))
      OP_LUI:   res = imm;
      OP_AUIPC: res = pc_plus_imm;
      OP_JAL: begin
        res    = pc_plus4;
        is_br  = 1'b1;
        taken  = 1'b1;
        target = pc_plus_imm;
      end
      OP_JALR: begin
        res    = pc_plus4;
        is_br  = 1'b1;
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OP_BEQ:   begin cond_br = 1'b1; taken = eq;    end
      OP_BNE:   begin cond_br = 1'b1; taken = !eq;   end
      OP_BLT:   begin cond_br = 1'b1; taken = lt_s;  end
      OP_BGE:   begin cond_br = 1'b1; taken = !lt_s; end
      OP_BLTU:  begin cond_br = 1'b1; taken = lt_u;  end
      OP_BGEU:  begin cond_br = 1'b1; taken = !lt_u; end
      OP_ADDI:  res = val1 + imm;
      OP_SLTI:  res = {{(XLEN-1){1'b0}}, $signed(val1) < $signed(imm)};
      OP_SLTIU: res = {{(XLEN-1){1'b0}}, val1 < imm};
      OP_XORI:  res = val1 ^ imm;
      OP_ORI:   res = val1 | imm;
      OP_ANDI:  res = val1 & imm;
      OP_SLLI:  res = val1 << shamt_i;
      OP_SRLI:  res = val1 >> shamt_i;
      OP_SRAI:  res = $unsigned($signed(val1) >>> shamt_i);
      OP_ADD:   res = val1 + val2;
      OP_SUB:   res = val1 - val2;
      OP_SLL:   res = val1 << shamt_r;
      OP_SLT:   res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU:  res = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:   res = val1 ^ val2;
      OP_SRL:   res = val1 >> shamt_r;
      OP_SRA:   res = $unsigned($signed(val1) >>> shamt_r);
      OP_OR:    res = val1 | val2;
      OP_AND:   res = val1 & val2;
      default:  res = '0;
    endcase
    // Conditional branches share result/target formation once direction is known.
    if (cond_br) begin
      is_br  = 1'b1;
      res    = {{(XLEN-1){1'b0}}, taken};
      target = taken ? pc_plus_imm : pc_plus4;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// ALU execution unit: registers the alu_core result onto the ALU result bus
// one cycle after issue, with flush and global-stall handling.
module alu_unit #(
  parameter int unsigned ROB_W = alu_pkg::ROB_W,
  parameter int unsigned OP_W  = alu_pkg::OP_W,
  parameter int unsigned XLEN  = alu_pkg::XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             work_en,
  input  logic [OP_W-1:0]  opcode_from_rs,
  input  logic [ROB_W-1:0] rob_id_from_rs,
  input  logic [XLEN-1:0]  val1,
  input  logic [XLEN-1:0]  val2,
  input  logic [XLEN-1:0]  imm_from_rs,
  input  logic [XLEN-1:0]  pc_from_rs,
  output logic             is_alu_ok,
  output logic [ROB_W-1:0] rob_id_from_alu,
  output logic [XLEN-1:0]  res_from_alu,
  output logic             alu_is_br,
  output logic             alu_taken,
  output logic [XLEN-1:0]  alu_target
);

  import alu_pkg::*;

  logic [XLEN-1:0] core_res;
  logic            core_is_br;
  logic            core_taken;
  logic [XLEN-1:0] core_target;

  alu_core u_core (
    .opcode (opcode_from_rs),
    .val1   (val1),
    .val2   (val2),
    .imm    (imm_from_rs),
    .pc     (pc_from_rs),
    .res    (core_res),
    .is_br  (core_is_br),
    .taken  (core_taken),
    .target (core_target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_alu_ok       <= 1'b0;
      alu_is_br       <= 1'b0;
      alu_taken       <= 1'b0;
      rob_id_from_alu <= '0;
      res_from_alu    <= '0;
      alu_target      <= '0;
    end else if (clear) begin
      is_alu_ok <= 1'b0;
      alu_is_br <= 1'b0;
      alu_taken <= 1'b0;
    end else if (rdy) begin
      if (work_en) begin
        is_alu_ok       <= 1'b1;
        alu_is_br       <= core_is_br;
        alu_taken       <= core_taken;
        rob_id_from_alu <= rob_id_from_rs;
        res_from_alu    <= core_res;
        alu_target      <= core_target;
      end else begin
        is_alu_ok <= 1'b0;
        alu_is_br <= 1'b0;
        alu_taken <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed literal cases plus randomized
// traffic compared every cycle against a behavioural model.
module tb_alu_unit;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        work_en;
  logic [5:0]  opcode_from_rs;
  logic [3:0]  rob_id_from_rs;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [31:0] imm_from_rs;
  logic [31:0] pc_from_rs;
  logic        is_alu_ok;
  logic [3:0]  rob_id_from_alu;
  logic [31:0] res_from_alu;
  logic        alu_is_br;
  logic        alu_taken;
  logic [31:0] alu_target;

  int checks;
  int failures;
  bit cmp_en;

  alu_unit #(.ROB_W(4), .OP_W(6), .XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .clear           (clear),
    .work_en         (work_en),
    .opcode_from_rs  (opcode_from_rs),
    .rob_id_from_rs  (rob_id_from_rs),
    .val1            (val1),
    .val2            (val2),
    .imm_from_rs     (imm_from_rs),
    .pc_from_rs      (pc_from_rs),
    .is_alu_ok       (is_alu_ok),
    .rob_id_from_alu (rob_id_from_alu),
    .res_from_alu    (res_from_alu),
    .alu_is_br       (alu_is_br),
    .alu_taken       (alu_taken),
    .alu_target      (alu_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
  } exp_t;

  function automatic exp_t ref_op(int op, logic [31:0] a, logic [31:0] b,
                                  logic [31:0] i, logic [31:0] p);
    exp_t e;
    int sa, sb, si;
    bit t;
    sa = int'(a);
    sb = int'(b);
    si = int'(i);
    e.res = 32'd0;
    e.br  = 1'b0;
    e.tk  = 1'b0;
    e.tgt = p + 32'd4;
    t     = 1'b0;
    if (op >= 4 && op <= 9) begin
      case (op)
        4: t = (a == b);
        5: t = (a != b);
        6: t = (sa < sb);
        7: t = (sa >= sb);
        8: t = (a < b);
        default: t = (a >= b);
      endcase
      e.br  = 1'b1;
      e.tk  = t;
      e.res = t ? 32'd1 : 32'd0;
      e.tgt = t ? p + i : p + 32'd4;
    end else begin
      case (op)
        0:  e.res = i;
        1:  e.res = p + i;
        2:  begin e.res = p + 32'd4; e.br = 1'b1; e.tk = 1'b1; e.tgt = p + i; end
        3:  begin e.res = p + 32'd4; e.br = 1'b1; e.tk = 1'b1; e.tgt = (a + i) & 32'hFFFF_FFFE; end
        10: e.res = a + i;
        11: e.res = (sa < si) ? 32'd1 : 32'd0;
        12: e.res = (a < i) ? 32'd1 : 32'd0;
        13: e.res = a ^ i;
        14: e.res = a | i;
        15: e.res = a & i;
        16: e.res = a << i[4:0];
        17: e.res = a >> i[4:0];
        18: e.res = 32'(sa >>> i[4:0]);
        19: e.res = a + b;
        20: e.res = a - b;
        21: e.res = a << b[4:0];
        22: e.res = (sa < sb) ? 32'd1 : 32'd0;
        23: e.res = (a < b) ? 32'd1 : 32'd0;
        24: e.res = a ^ b;
        25: e.res = a >> b[4:0];
        26: e.res = 32'(sa >>> b[4:0]);
        27: e.res = a | b;
        28: e.res = a & b;
        default: e.res = 32'd0;
      endcase
    end
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model of the result bus.
  logic       m_ok;
  logic [3:0] m_rob;
  exp_t       m_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ok  <= 1'b0;
      m_rob <= 4'd0;
      m_e   <= '0;
    end else if (clear) begin
      m_ok   <= 1'b0;
      m_e.br <= 1'b0;
      m_e.tk <= 1'b0;
    end else if (rdy) begin
      if (work_en) begin
        m_ok  <= 1'b1;
        m_rob <= rob_id_from_rs;
        m_e   <= ref_op(int'(opcode_from_rs), val1, val2, imm_from_rs, pc_from_rs);
      end else begin
        m_ok   <= 1'b0;
        m_e.br <= 1'b0;
        m_e.tk <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("m_ok", 32'(is_alu_ok), 32'(m_ok));
      chk("m_br", 32'(alu_is_br), 32'(m_e.br));
      chk("m_taken", 32'(alu_taken), 32'(m_e.tk));
      if (m_ok) begin
        chk("m_rob", 32'(rob_id_from_alu), 32'(m_rob));
        chk("m_res", res_from_alu, m_e.res);
        chk("m_target", alu_target, m_e.tgt);
      end
    end
  end

  task automatic issue(alu_op_e op, logic [3:0] rob, logic [31:0] a, logic [31:0] b,
                       logic [31:0] i, logic [31:0] p);
    work_en        = 1'b1;
    opcode_from_rs = op;
    rob_id_from_rs = rob;
    val1           = a;
    val2           = b;
    imm_from_rs    = i;
    pc_from_rs     = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t pin;
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    rst      = 1'b1;
    rdy      = 1'b1;
    clear    = 1'b0;
    work_en  = 1'b0;
    opcode_from_rs = '0;
    rob_id_from_rs = '0;
    val1 = '0; val2 = '0; imm_from_rs = '0; pc_from_rs = '0;

    pin = ref_op(int'(OP_SRAI), 32'h8000_0000, 32'd0, 32'd4, 32'd0);
    chk("pin_srai", pin.res, 32'hF800_0000);
    pin = ref_op(int'(OP_JALR), 32'h1001, 32'd0, 32'd2, 32'h40);
    chk("pin_jalr", pin.tgt, 32'h1002);

    repeat (3) @(negedge clk);
    chk("rst_ok", 32'(is_alu_ok), 32'd0);
    chk("rst_br", 32'(alu_is_br), 32'd0);
    chk("rst_taken", 32'(alu_taken), 32'd0);
    chk("rst_rob", 32'(rob_id_from_alu), 32'd0);
    chk("rst_res", res_from_alu, 32'd0);
    chk("rst_target", alu_target, 32'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    issue(OP_ADD, 4'd3, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd0);
    @(negedge clk);
    work_en = 1'b0;
    chk("add_ok", 32'(is_alu_ok), 32'd1);
    chk("add_rob", 32'(rob_id_from_alu), 32'd3);
    chk("add_res", res_from_alu, 32'd4);
    chk("add_br", 32'(alu_is_br), 32'd0);
    @(negedge clk);
    chk("add_ok_drop", 32'(is_alu_ok), 32'd0);

    issue(OP_SRAI, 4'd1, 32'h8000_0000, 32'd0, 32'd4, 32'd0);
    @(negedge clk);
    issue(OP_SLTU, 4'd2, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
    chk("srai_res", res_from_alu, 32'hF800_0000);
    chk("srai_rob", 32'(rob_id_from_alu), 32'd1);
    @(negedge clk);
    issue(OP_SLT, 4'd3, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
    chk("sltu_res", res_from_alu, 32'd1);
    chk("sltu_rob", 32'(rob_id_from_alu), 32'd2);
    @(negedge clk);
    work_en = 1'b0;
    chk("slt_res", res_from_alu, 32'd0);
    chk("slt_rob", 32'(rob_id_from_alu), 32'd3);
    chk("slt_ok", 32'(is_alu_ok), 32'd1);

    issue(OP_BLT, 4'd4, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100);
    @(negedge clk);
    issue(OP_BGEU, 4'd5, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100);
    chk("blt_taken", 32'(alu_taken), 32'd1);
    chk("blt_target", alu_target, 32'h120);
    chk("blt_res", res_from_alu, 32'd1);
    @(negedge clk);
    issue(OP_BEQ, 4'd6, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100);
    chk("bgeu_taken", 32'(alu_taken), 32'd1);
    @(negedge clk);
    issue(OP_JALR, 4'd7, 32'h1001, 32'd0, 32'd2, 32'h40);
    chk("beq_taken", 32'(alu_taken), 32'd0);
    chk("beq_target", alu_target, 32'h104);
    chk("beq_br", 32'(alu_is_br), 32'd1);
    @(negedge clk);
    issue(OP_JAL, 4'd8, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h40);
    chk("jalr_res", res_from_alu, 32'h44);
    chk("jalr_target", alu_target, 32'h1002);
    chk("jalr_taken", 32'(alu_taken), 32'd1);
    @(negedge clk);
    issue(OP_ADD, 4'd9, 32'd7, 32'd8, 32'd0, 32'd0);
    clear = 1'b1;
    chk("jal_target", alu_target, 32'h38);
    chk("jal_res", res_from_alu, 32'h44);
    @(negedge clk);
    clear = 1'b0;
    chk("clear_ok", 32'(is_alu_ok), 32'd0);
    issue(OP_ADD, 4'd7, 32'd1, 32'd2, 32'd0, 32'd0);
    @(negedge clk);
    rdy = 1'b0;
    issue(OP_SUB, 4'd9, 32'd10, 32'd3, 32'd0, 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stall_ok", 32'(is_alu_ok), 32'd1);
      chk("stall_rob", 32'(rob_id_from_alu), 32'd7);
      chk("stall_res", res_from_alu, 32'd3);
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("resume_rob", 32'(rob_id_from_alu), 32'd9);
    chk("resume_res", res_from_alu, 32'd7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ok", 32'(is_alu_ok), 32'd0);
    chk("async_rst_res", res_from_alu, 32'd0);
    @(negedge clk);
    work_en = 1'b0;
    rst     = 1'b0;

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      work_en        = ($urandom_range(0, 9) != 0);
      clear          = ($urandom_range(0, 19) == 0);
      rdy            = ($urandom_range(0, 7) != 0);
      opcode_from_rs = 6'($urandom_range(0, 31));
      rob_id_from_rs = 4'($urandom);
      val1           = $urandom;
      val2           = ($urandom_range(0, 3) == 0) ? val1 : $urandom;
      imm_from_rs    = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      pc_from_rs     = $urandom & 32'hFFFF_FFFC;
    end
    @(negedge clk);
    work_en = 1'b0;
    clear   = 1'b0;
    rdy     = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Execution unit at the consuming end of the reservation-station issue interface.
- Each cycle it accepts at most one ready operation (work_en, opcode, rob_id, val1, val2, imm, pc) from the reservation station.
- It computes the RV32I integer/branch/jump result and broadcasts it one cycle later on the ALU result bus (is_alu_ok, rob_id_from_alu, res_from_alu). The reservation station, ROB and LSB snoop that bus.
- For control-flow ops it also reports resolved direction and target to the ROB.

Parameters:
- ROB_W, 4, width of ROB tag.
- OP_W, 6, width of opcode field.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global enable; low = stall.
- clear  in  1  pipeline flush (branch mispredict), synchronous.
- work_en  in  1  valid operation presented this cycle.
- opcode_from_rs  in  OP_W  operation code (alu_pkg encoding).
- rob_id_from_rs  in  ROB_W  destination ROB tag.
- val1  in  XLEN  rs1 value.
- val2  in  XLEN  rs2 value.
- imm_from_rs  in  XLEN  sign-extended immediate; U-type already shifted.
- pc_from_rs  in  XLEN  instruction PC.
- is_alu_ok  out  1  result valid.
- rob_id_from_alu  out  ROB_W  tag of result.
- res_from_alu  out  XLEN  result value.
- alu_is_br  out  1  result belongs to a branch/JAL/JALR.
- alu_taken  out  1  control transfer taken.
- alu_target  out  XLEN  actual next PC when taken; pc+4 otherwise.

Behaviour:
- Reset (async, rst=1): is_alu_ok=0, alu_is_br=0, alu_taken=0; rob_id_from_alu=0, res_from_alu=0, alu_target=0.
- Priority at each clk edge: rst > clear > !rdy > normal.
- clear=1: is_alu_ok<=0, alu_is_br<=0, alu_taken<=0, regardless of work_en. The operation on the inputs that cycle is discarded.
- rdy=0: all outputs hold their values; inputs are ignored.
- Normal, work_en=1: outputs register the computed values; latency is exactly 1 cycle. There is no back-pressure, so one op is accepted every cycle.
- Normal, work_en=0: is_alu_ok<=0, alu_is_br<=0, alu_taken<=0; data outputs may hold.
- Arithmetic is mod 2^32. Shift amount is bits [4:0] of imm (I-type) or val2 (R-type). SLT/SLTI compare signed; SLTU/SLTIU compare unsigned; SRA/SRAI shift arithmetically.
- LUI: res=imm.
- AUIPC: res=pc+imm.
- JAL: res=pc+4; taken=1; target=pc+imm.
- JALR: res=pc+4; taken=1; target=(val1+imm) & ~1.
- BEQ/BNE/BLT/BGE/BLTU/BGEU:
  - Compare val1 against val2; res={31'b0,taken}.
  - target=pc+imm if taken, else pc+4.
  - alu_is_br=1 whether taken or not.
- Non-control ops: alu_is_br=0, alu_taken=0, alu_target=pc+4.
- Undefined opcode: is_alu_ok=1, res=0, alu_is_br=0. It is never dropped, because the ROB waits on the tag.
- Back-to-back ops produce back-to-back results, and the tag always travels with its op.

Decomposition:
- Shared package alu_pkg holds the opcode constants 0..28 in this order: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. It also holds XLEN and ROB_W. The dispatcher and the reservation station import the same package.
- One combinational sub-module, alu_core, maps opcode/operands to res, is_br, taken and target. alu_unit contains only the output register, rdy/clear/rst handling, and the instantiation.

Test Plan:
- ADD val1=5, val2=0xFFFFFFFF, rob=3 with work_en pulse -> next cycle is_alu_ok=1, rob_id_from_alu=3, res=4, alu_is_br=0; cycle after, is_alu_ok=0.
- SRAI val1=0x80000000, imm=4; SLTU val1=1, val2=0xFFFFFFFF; SLT same operands -> res=0xF8000000, 1 and 0 on three consecutive cycles, with tags 1, 2, 3 in order.
- BLT val1=-1, val2=0, pc=0x100, imm=0x20 -> taken=1, target=0x120, res=1. BGEU with the same operands -> taken=1. BEQ with the same operands -> taken=0, target=0x104, alu_is_br=1.
- JALR val1=0x1001, imm=2, pc=0x40 -> res=0x44, target=0x1002, taken=1. JAL pc=0x40, imm=-8 -> target=0x38.
- work_en=1 with clear=1 on the same edge -> is_alu_ok stays 0. Then drop rdy for 3 cycles while a result is valid -> outputs frozen. On rdy=1 -> normal operation resumes.
- Assert rst asynchronously between edges while is_alu_ok=1 -> is_alu_ok falls immediately, without waiting for a clock edge.
